pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameters: NSTAGE, default 5, pipeline stage count (>=4; stage 0 fetch, 1 decode, 2 execute, NSTAGE-2 memory, NSTAGE-1 writeback).
REQ-002 The block SHALL have parameter NREG, default 32, architectural register count.
REQ-003 The block SHALL have parameter RAW, default $clog2(NREG), register address width.
REQ-004 clk  in  1  clock; one clock domain; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 fetch_valid  in  1  instruction word present at fetch this cycle.
REQ-007 dec_rs, dec_rt  in  RAW each  source registers of the instruction in decode.
REQ-008 dec_use_rs, dec_use_rt  in  1 each  the corresponding source is read.
REQ-009 dec_wa  in  RAW  destination register of the decode instruction; dec_we  in  1  it writes a register.
REQ-010 mem_ready  in  1  data memory completes the access this cycle.
REQ-011 redirect  in  1  taken branch or jump resolved in execute.
REQ-012 stage_enable  out  NSTAGE  per-stage register load enable.
REQ-013 stage_valid  out  NSTAGE  per-stage holds a live instruction.
REQ-014 stall_hazard, stall_mem  out  1 each  stall cause flags.
REQ-015 wb_fire  out  1  a valid writing instruction retires this cycle.
REQ-016 busy  out  1  OR of stage_valid[NSTAGE-1:2].

Function
REQ-017 mem_stall SHALL equal stage_valid[NSTAGE-2] & ~mem_ready; stall_mem = mem_stall.
REQ-018 hazard SHALL equal stage_valid[1] & ((dec_use_rs & dec_rs!=0 & cnt[dec_rs]!=0) | (dec_use_rt & dec_rt!=0 & cnt[dec_rt]!=0)); stall_hazard = hazard & ~mem_stall & ~redirect.
REQ-019 Enables SHALL be: stage_enable[NSTAGE-1]=1; stages 2..NSTAGE-2 = ~mem_stall; stages 0,1 = ~mem_stall & ~stall_hazard.
REQ-020 On an enabled edge, valid[0] SHALL load fetch_valid and valid[i] (i>=1) SHALL load valid[i-1]; a disabled stage SHALL hold its value.
REQ-021 A bubble SHALL be inserted: if stage_enable[i]=1 and stage_enable[i-1]=0, valid[i] loads 0.
REQ-022 redirect SHALL take effect only when mem_stall=0; then valid[0], valid[1], valid[2] SHALL load 0, overriding hazard; with mem_stall=1 it SHALL be ignored (the source re-asserts).
REQ-023 The block SHALL shift dec_wa/dec_we into a per-stage tag pipe (stages 2..NSTAGE-1) under the same enables; bubbles carry we=0.
REQ-024 cnt[r] SHALL be a per-register pending-write counter of width $clog2(NSTAGE).
REQ-025 cnt[dec_wa] SHALL increment when decode issues into stage 2 (valid[1], stage_enable[2], not hazard, not redirect, dec_we, dec_wa!=0).
REQ-026 cnt[wa_NSTAGE-1] SHALL decrement when valid[NSTAGE-1] & we_NSTAGE-1 (=wb_fire).
REQ-027 When an increment and a decrement hit the same register in one cycle, that count SHALL be unchanged; register 0 SHALL never count.
REQ-028 Hazard SHALL use pre-update counts: a consumer leaves decode the cycle after its producer's wb_fire.
REQ-029 Outputs other than the registered valids, tags and counts SHALL be combinational.

Reset
REQ-030 While reset=1: all valids 0, all counters 0, all tags we=0; stage_enable all 1, stall flags 0, wb_fire 0, busy 0 on the cycle following reset.
REQ-031 Reset mid-operation SHALL discard all in-flight instructions and pending counts in one cycle.

Verification
REQ-032 Stream of 6 fetch_valid=1 instructions, no dependences, mem_ready=1 -> first wb_fire 4 cycles after entering stage 0 (NSTAGE=5), one retire per cycle, stall flags never 1.
REQ-033 Producer dec_wa=3 we=1 followed by consumer dec_rs=3 -> stall_hazard high 3 cycles, bubbles in execute, consumer issues cycle after producer wb_fire; cnt[3] returns to 0.
REQ-034 Producer and consumer on register 0 -> no stall, cnt[0] stays 0.
REQ-035 Load in memory with mem_ready=0 for 2 cycles -> stages 0..3 hold, two bubbles reach writeback, stall_mem high exactly 2 cycles.
REQ-036 redirect coincident with hazard -> valid[0..2] become 0, no increment for the killed decode instruction; redirect during mem_stall -> no effect.
REQ-037 reset asserted with 4 valid stages and cnt[5]=2 -> next cycle all valids 0, cnt[5]=0, busy 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// In-order pipeline controller: per-stage valids and enables, bubble insertion,
// branch kill, and scoreboard counters for RAW hazard detection at decode.
module pipe_ctrl #(
    parameter int NSTAGE = 5,
    parameter int NREG   = 32,
    parameter int RAW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_valid,
    input  logic [RAW-1:0]    dec_rs,
    input  logic [RAW-1:0]    dec_rt,
    input  logic              dec_use_rs,
    input  logic              dec_use_rt,
    input  logic [RAW-1:0]    dec_wa,
    input  logic              dec_we,
    input  logic              mem_ready,
    input  logic              redirect,
    output logic [NSTAGE-1:0] stage_enable,
    output logic [NSTAGE-1:0] stage_valid,
    output logic              stall_hazard,
    output logic              stall_mem,
    output logic              wb_fire,
    output logic              busy
);

    localparam int CW = $clog2(NSTAGE);

    logic [NSTAGE-1:0] valid;
    logic [RAW-1:0]    tag_wa [2:NSTAGE-1];
    logic [NSTAGE-1:2] tag_we;
    logic [CW-1:0]     cnt [NREG];

    logic           mem_stall;
    logic           hazard;
    logic           redir_eff;
    logic           issue;
    logic           inc_en;
    logic           dec_en;
    logic [RAW-1:0] wb_wa;

    always_comb begin
        mem_stall    = valid[NSTAGE-2] & ~mem_ready;
        hazard       = valid[1] &
                       ((dec_use_rs & (dec_rs != '0) & (cnt[dec_rs] != '0)) |
                        (dec_use_rt & (dec_rt != '0) & (cnt[dec_rt] != '0)));
        stall_hazard = hazard & ~mem_stall & ~redirect;
        stall_mem    = mem_stall;
        redir_eff    = redirect & ~mem_stall;

        stage_enable             = {NSTAGE{~mem_stall}};
        stage_enable[NSTAGE-1]   = 1'b1;
        stage_enable[1:0]        = {2{~mem_stall & ~stall_hazard}};

        issue   = valid[1] & stage_enable[2] & ~hazard & ~redirect;
        inc_en  = issue & dec_we & (dec_wa != '0);
        wb_wa   = tag_wa[NSTAGE-1];
        wb_fire = valid[NSTAGE-1] & tag_we[NSTAGE-1];
        dec_en  = wb_fire & (wb_wa != '0);

        busy        = |valid[NSTAGE-1:2];
        stage_valid = valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid  <= '0;
            tag_we <= '0;
            for (int unsigned i = 2; i < NSTAGE; i++) tag_wa[i] <= '0;
            for (int unsigned r = 0; r < NREG; r++)   cnt[r]    <= '0;
        end else begin
            if (stage_enable[0]) valid[0] <= fetch_valid & ~redir_eff;
            // A stage fed by a held stage receives a bubble; redirect also kills the
            // instruction entering execute.
            for (int unsigned i = 1; i < NSTAGE; i++) begin
                if (stage_enable[i])
                    valid[i] <= valid[i-1] & stage_enable[i-1] & ~(redir_eff && i <= 2);
            end

            if (stage_enable[2]) begin
                tag_wa[2] <= dec_wa;
                tag_we[2] <= dec_we & issue;
            end
            for (int unsigned i = 3; i < NSTAGE; i++) begin
                if (stage_enable[i]) begin
                    tag_wa[i] <= tag_wa[i-1];
                    tag_we[i] <= tag_we[i-1] & stage_enable[i-1];
                end
            end

            // Register 0 is never written here, so its count stays at reset value.
            for (int unsigned r = 1; r < NREG; r++) begin
                if (inc_en && dec_wa == RAW'(r) && !(dec_en && wb_wa == RAW'(r)))
                    cnt[r] <= cnt[r] + 1'b1;
                else if (dec_en && wb_wa == RAW'(r) && !(inc_en && dec_wa == RAW'(r)))
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl against an instruction-slot model
// whose pending writes are found by scanning in-flight instructions.
module tb_pipe_ctrl;

    localparam int NS = 5;
    localparam int NR = 32;
    localparam int RW = 5;

    typedef struct packed {
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] wa;
        logic          urs;
        logic          urt;
        logic          we;
    } ins_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_valid;
    logic [RW-1:0] dec_rs, dec_rt, dec_wa;
    logic          dec_use_rs, dec_use_rt, dec_we;
    logic          mem_ready;
    logic          redirect;
    logic [NS-1:0] stage_enable;
    logic [NS-1:0] stage_valid;
    logic          stall_hazard, stall_mem, wb_fire, busy;

    pipe_ctrl #(.NSTAGE(NS), .NREG(NR), .RAW(RW)) dut (
        .clk(clk), .reset(reset), .fetch_valid(fetch_valid),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt),
        .dec_wa(dec_wa), .dec_we(dec_we), .mem_ready(mem_ready), .redirect(redirect),
        .stage_enable(stage_enable), .stage_valid(stage_valid),
        .stall_hazard(stall_hazard), .stall_mem(stall_mem), .wb_fire(wb_fire), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit   m_v [NS];
    ins_t m_i [NS];
    bit   chk_on = 0;
    bit   obs_sh, obs_sm, obs_wb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ins_t rand_ins();
        ins_t r;
        r.rs  = RW'($urandom_range(0, 7));
        r.rt  = RW'($urandom_range(0, 7));
        r.wa  = RW'($urandom_range(0, 7));
        r.urs = 1'($urandom_range(0, 1));
        r.urt = 1'($urandom_range(0, 1));
        r.we  = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic ins_t mk(input int rs, input int rt, input int wa,
                                input bit urs, input bit urt, input bit we);
        ins_t r;
        r.rs = RW'(rs); r.rt = RW'(rt); r.wa = RW'(wa);
        r.urs = urs; r.urt = urt; r.we = we;
        return r;
    endfunction

    // Writes still in flight (issued past decode, not yet retired) to register r.
    function automatic int pend(input logic [RW-1:0] r);
        int n = 0;
        for (int i = 2; i < NS; i++)
            if (m_v[i] && m_i[i].we && m_i[i].wa == r) n++;
        return n;
    endfunction

    task automatic step(input bit fv, input ins_t in, input bit mr, input bit rd, input bit rst);
        ins_t d;
        bit ms, hz, sh, ewb;
        logic [NS-1:0] ev, een;
        @(negedge clk);
        d = m_v[1] ? m_i[1] : rand_ins();
        fetch_valid = fv; mem_ready = mr; redirect = rd; reset = rst;
        dec_rs = d.rs; dec_rt = d.rt; dec_wa = d.wa;
        dec_use_rs = d.urs; dec_use_rt = d.urt; dec_we = d.we;
        #1;
        for (int i = 0; i < NS; i++) ev[i] = m_v[i];
        ms  = m_v[NS-2] && !mr;
        hz  = m_v[1] && ((d.urs && d.rs != 0 && pend(d.rs) != 0) ||
                         (d.urt && d.rt != 0 && pend(d.rt) != 0));
        sh  = hz && !ms && !rd;
        for (int i = 0; i < NS; i++)
            een[i] = (i == NS-1) ? 1'b1 : (i >= 2 ? !ms : (!ms && !sh));
        ewb = m_v[NS-1] && m_i[NS-1].we;
        obs_sh = stall_hazard; obs_sm = stall_mem; obs_wb = wb_fire;
        if (chk_on) begin
            check("stage_valid",  32'(stage_valid),  32'(ev));
            check("stage_enable", 32'(stage_enable), 32'(een));
            check("stall_hazard", 32'(stall_hazard), 32'(sh));
            check("stall_mem",    32'(stall_mem),    32'(ms));
            check("wb_fire",      32'(wb_fire),      32'(ewb));
            check("busy",         32'(busy),         32'(|ev[NS-1:2]));
        end
        if (rst) begin
            for (int i = 0; i < NS; i++) begin m_v[i] = 0; m_i[i] = '0; end
            chk_on = 1;
        end else if (ms) begin
            m_v[NS-1] = 0;
        end else begin
            for (int i = NS-1; i >= 3; i--) begin m_v[i] = m_v[i-1]; m_i[i] = m_i[i-1]; end
            if (sh || rd) begin m_v[2] = 0; m_i[2] = '0; end
            else begin m_v[2] = m_v[1]; m_i[2] = m_i[1]; end
            if (!sh) begin
                m_v[1] = m_v[0]; m_i[1] = m_i[0];
                m_v[0] = fv;     m_i[0] = in;
            end
            if (rd) begin m_v[0] = 0; m_v[1] = 0; end
        end
    endtask

    task automatic nop(input int n);
        for (int k = 0; k < n; k++) step(0, '0, 1, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_wb, n_wb, n_sh, n_sm, stalls;
        bit hit;
        logic [NS-1:0] mv;

        reset = 1; fetch_valid = 0; mem_ready = 1; redirect = 0;
        dec_rs = '0; dec_rt = '0; dec_wa = '0; dec_use_rs = 0; dec_use_rt = 0; dec_we = 0;
        for (int i = 0; i < NS; i++) begin m_v[i] = 0; m_i[i] = '0; end

        step(0, '0, 1, 0, 1);
        step(0, '0, 1, 0, 1);
        settle();
        check("rst_valid",  32'(stage_valid),  32'h0);
        check("rst_enable", 32'(stage_enable), 32'h1f);
        check("rst_flags",  32'({stall_hazard, stall_mem, wb_fire, busy}), 32'h0);

        // Independent stream: latency to first retire and back-to-back retires.
        first_wb = -1; n_wb = 0; stalls = 0;
        for (int k = 0; k < 14; k++) begin
            step(k < 6, mk(0, 0, k + 1, 0, 0, 1), 1, 0, 0);
            if (obs_wb) begin
                if (first_wb < 0) first_wb = k;
                n_wb++;
            end
            if (obs_sh || obs_sm) stalls++;
        end
        check("first_wb_step", 32'(first_wb), 32'd5);
        check("retire_count",  32'(n_wb),     32'd6);
        check("stream_stalls", 32'(stalls),   32'd0);

        // Producer r3 then consumer of r3: three hazard cycles, count drains.
        n_sh = 0;
        step(1, mk(0, 0, 3, 0, 0, 1), 1, 0, 0);
        step(1, mk(3, 0, 0, 1, 0, 0), 1, 0, 0);
        for (int k = 0; k < 10; k++) begin step(0, '0, 1, 0, 0); if (obs_sh) n_sh++; end
        check("raw_r3_stalls", 32'(n_sh), 32'd3);
        n_sh = 0;
        step(1, mk(3, 3, 0, 1, 1, 0), 1, 0, 0);
        for (int k = 0; k < 6; k++) begin step(0, '0, 1, 0, 0); if (obs_sh) n_sh++; end
        check("r3_drained", 32'(n_sh), 32'd0);

        // Register 0 never creates a dependence.
        n_sh = 0;
        step(1, mk(0, 0, 0, 0, 0, 1), 1, 0, 0);
        step(1, mk(0, 0, 0, 1, 1, 0), 1, 0, 0);
        for (int k = 0; k < 8; k++) begin step(0, '0, 1, 0, 0); if (obs_sh) n_sh++; end
        check("r0_no_stall", 32'(n_sh), 32'd0);

        // Memory wait of two cycles on the first instruction reaching memory.
        n_sm = 0; stalls = 2;
        for (int k = 0; k < 12; k++) begin
            bit mr;
            mr = !(m_v[NS-2] && stalls > 0);
            if (!mr) stalls--;
            step(k < 4, mk(0, 0, 9, 0, 0, 1), mr, 0, 0);
            if (obs_sm) n_sm++;
        end
        check("mem_stall_cycles", 32'(n_sm), 32'd2);

        // Redirect coincident with a hazard kills fetch/decode/execute entry.
        step(1, mk(0, 0, 4, 0, 0, 1), 1, 0, 0);
        step(1, mk(4, 0, 6, 1, 0, 1), 1, 0, 0);
        step(1, '0, 1, 0, 0);
        hit = 0;
        for (int k = 0; k < 6 && !hit; k++) begin
            if (m_v[1] && pend(m_i[1].rs) != 0) begin
                step(0, '0, 1, 1, 0);
                hit = 1;
            end else begin
                step(0, '0, 1, 0, 0);
            end
        end
        check("redir_hazard_seen", 32'(hit), 32'd1);
        settle();
        check("redir_kill", 32'(stage_valid[2:0]), 32'h0);
        nop(6);
        n_sh = 0;
        step(1, mk(6, 0, 0, 1, 0, 0), 1, 0, 0);
        for (int k = 0; k < 5; k++) begin step(0, '0, 1, 0, 0); if (obs_sh) n_sh++; end
        check("killed_no_count", 32'(n_sh), 32'd0);

        // Redirect while memory stalls is ignored.
        for (int k = 0; k < 4; k++) step(1, '0, 1, 0, 0);
        step(1, '0, 0, 1, 0);
        settle();
        for (int i = 0; i < NS; i++) mv[i] = m_v[i];
        check("redir_in_mstall", 32'(stage_valid), 32'(mv));
        nop(6);

        // Reset with four valid stages and two pending writes to r5.
        step(1, mk(0, 0, 5, 0, 0, 1), 1, 0, 0);
        step(1, mk(0, 0, 5, 0, 0, 1), 1, 0, 0);
        step(1, '0, 1, 0, 0);
        step(1, '0, 1, 0, 0);
        check("pre_rst_pend5", 32'(pend(5)), 32'd2);
        step(0, '0, 1, 0, 1);
        settle();
        check("mid_rst_valid", 32'(stage_valid), 32'h0);
        check("mid_rst_busy",  32'(busy),        32'h0);
        n_sh = 0;
        step(1, mk(5, 5, 0, 1, 1, 0), 1, 0, 0);
        for (int k = 0; k < 4; k++) begin step(0, '0, 1, 0, 0); if (obs_sh) n_sh++; end
        check("rst_cleared_cnt", 32'(n_sh), 32'd0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            step(1'($urandom_range(0, 3) != 0), rand_ins(),
                 $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
